// File: rtl/rf_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rf_cmd_pkg                                                       |
// | Brief   : Opcodes, FSM states and width defaults for regfile_cmd_master.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rf_cmd_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 2;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_ADD   = 2'b10,
      OP_SWAP  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR1  = 3'd2,
      ST_WR2  = 3'd3,
      ST_RSP  = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : regfile_cmd_master                                               |
// | Brief   : Command-driven initiator sequencing reads/writes of a register   |
// |           file; every rf_* output is registered so writes are glitch-free. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_cmd_master
   import rf_cmd_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data1,
   output logic [DATA_W-1:0] rsp_data2,
   output logic [ADDR_W-1:0] rf_read_reg1,
   output logic [ADDR_W-1:0] rf_read_reg2,
   input  logic [DATA_W-1:0] rf_read_data1,
   input  logic [DATA_W-1:0] rf_read_data2,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_reg_write
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] op1_q, op1_d;
   logic [ADDR_W-1:0] rreg1_q, rreg1_d;
   logic [ADDR_W-1:0] rreg2_q, rreg2_d;
   logic [ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rsp1_q, rsp1_d;
   logic [DATA_W-1:0] rsp2_q, rsp2_d;
   logic [DATA_W:0]   sum;

   // Single adder, fed straight from the read ports while in RD.
   assign sum = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rd_d    = rd_q;
      op1_d   = op1_q;
      rreg1_d = rreg1_q;
      rreg2_d = rreg2_q;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      rsp1_d  = rsp1_q;
      rsp2_d  = rsp2_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d    = op_e'(cmd_op);
               rd_d    = cmd_rd;
               rreg1_d = cmd_rs1;
               rreg2_d = cmd_rs2;
               if (op_e'(cmd_op) == OP_WRITE) begin
                  wreg_d  = cmd_rd;
                  wdata_d = cmd_wdata;
                  we_d    = 1'b1;
                  rsp1_d  = cmd_wdata;
                  rsp2_d  = '0;
                  state_d = ST_WR1;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            // Operands are frozen here so later writes never feed back into results.
            op1_d  = rf_read_data1;
            rsp1_d = rf_read_data1;
            rsp2_d = rf_read_data2;
            case (op_q)
               OP_ADD: begin
                  wreg_d  = rd_q;
                  wdata_d = sum[DATA_W-1:0];
                  we_d    = 1'b1;
                  rsp1_d  = sum[DATA_W-1:0];
                  rsp2_d  = {{(DATA_W-1){1'b0}}, sum[DATA_W]};
                  state_d = ST_WR1;
               end
               OP_SWAP: begin
                  wreg_d  = rreg1_q;
                  wdata_d = rf_read_data2;
                  we_d    = 1'b1;
                  state_d = ST_WR1;
               end
               default: state_d = ST_RSP;
            endcase
         end
         ST_WR1: begin
            if (op_q == OP_SWAP) begin
               wreg_d  = rreg2_q;
               wdata_d = op1_q;
               we_d    = 1'b1;
               state_d = ST_WR2;
            end else begin
               state_d = ST_RSP;
            end
         end
         ST_WR2: state_d = ST_RSP;
         ST_RSP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_READ;
         rd_q    <= '0;
         op1_q   <= '0;
         rreg1_q <= '0;
         rreg2_q <= '0;
         wreg_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rsp1_q  <= '0;
         rsp2_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         op1_q   <= op1_d;
         rreg1_q <= rreg1_d;
         rreg2_q <= rreg2_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rsp1_q  <= rsp1_d;
         rsp2_q  <= rsp2_d;
      end
   end

   assign cmd_ready     = (state_q == ST_IDLE);
   assign rsp_valid     = (state_q == ST_RSP);
   assign rsp_data1     = rsp1_q;
   assign rsp_data2     = rsp2_q;
   assign rf_read_reg1  = rreg1_q;
   assign rf_read_reg2  = rreg2_q;
   assign rf_write_reg  = wreg_q;
   assign rf_write_data = wdata_q;
   assign rf_reg_write  = we_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_regfile_cmd_master                                            |
// | Brief   : Directed bench for regfile_cmd_master with a 4x32 regfile model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_regfile_cmd_master;

   localparam logic [1:0] K_READ  = 2'b00;
   localparam logic [1:0] K_WRITE = 2'b01;
   localparam logic [1:0] K_ADD   = 2'b10;
   localparam logic [1:0] K_SWAP  = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [1:0]  cmd_rs1, cmd_rs2, cmd_rd;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data1, rsp_data2;
   logic [1:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
   logic [31:0] rf_read_data1, rf_read_data2, rf_write_data;
   logic        rf_reg_write;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int wr_log[$];
   int wr_cyc[$];

   logic [31:0] rf [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Register file: writes on the falling edge of clk & reg_write.
   assign rf_read_data1 = rf[rf_read_reg1];
   assign rf_read_data2 = rf[rf_read_reg2];
   always @(negedge clk) begin
      if (rf_reg_write) begin
         rf[rf_write_reg] <= rf_write_data;
         wr_log.push_back(int'(rf_write_reg));
         wr_cyc.push_back(cyc);
      end
   end

   regfile_cmd_master #(.DATA_W(32), .ADDR_W(2)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
      .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
      .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
      .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
      .rf_reg_write(rf_reg_write)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic check_writes(input string tag, input int n, input int i0, input int i1);
      int a0, a1, c0, c1;
      a0 = (wr_log.size() > 0) ? wr_log[0] : -1;
      a1 = (wr_log.size() > 1) ? wr_log[1] : -1;
      c0 = (wr_cyc.size() > 0) ? wr_cyc[0] : -1;
      c1 = (wr_cyc.size() > 1) ? wr_cyc[1] : -1;
      chk({tag, "_wr_count"}, wr_log.size(), n);
      if (n >= 1) chk({tag, "_wr_idx0"}, a0, i0);
      if (n >= 2) begin
         chk({tag, "_wr_idx1"}, a1, i1);
         chk({tag, "_wr_consec"}, c1 - c0, 1);
      end
   endtask

   // Issue one command, wait for the response (bounded), optionally stall it, then consume it.
   task automatic run_cmd(input logic [1:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [1:0] rd, input logic [31:0] wd, input int stall,
                          output int lat, output logic [31:0] d1, output logic [31:0] d2);
      @(negedge clk);
      cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_wdata = wd;
      cmd_valid = 1'b1;
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wr_log.delete();
      wr_cyc.delete();
      lat = 1;
      while (!rsp_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      d1 = rsp_data1;
      d2 = rsp_data2;
      if (stall > 0) begin
         cmd_op = K_WRITE; cmd_rd = 2'd0; cmd_wdata = 32'h12345678; cmd_valid = 1'b1;
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_rsp_valid", rsp_valid, 1);
         chk("stall_data1", rsp_data1, d1);
         chk("stall_data2", rsp_data2, d2);
         chk("stall_cmd_ready", cmd_ready, 0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      chk("cmd_ready_after_rsp", cmd_ready, 1);
      chk("rsp_valid_after_rsp", rsp_valid, 0);
   endtask

   initial begin
      int lat;
      logic [31:0] d1, d2;
      logic seen;

      reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = 2'b00; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_rd = 2'd0; cmd_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_reg_write", rf_reg_write, 0);
      chk("rst_write_data", rf_write_data, 32'h0);
      chk("rst_rsp_data1", rsp_data1, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      run_cmd(K_WRITE, 2'd0, 2'd0, 2'd2, 32'hDEADBEEF, 0, lat, d1, d2);
      chk("write_lat", lat, 2);
      check_writes("write", 1, 2, 0);
      chk("write_d1", d1, 32'hDEADBEEF);
      chk("write_d2", d2, 32'h0);

      run_cmd(K_WRITE, 2'd0, 2'd0, 2'd1, 32'd5, 0, lat, d1, d2);
      run_cmd(K_WRITE, 2'd0, 2'd0, 2'd2, 32'd7, 0, lat, d1, d2);
      run_cmd(K_READ, 2'd1, 2'd2, 2'd0, 32'h0, 0, lat, d1, d2);
      chk("read_lat", lat, 2);
      check_writes("read", 0, 0, 0);
      chk("read_d1", d1, 32'd5);
      chk("read_d2", d2, 32'd7);

      run_cmd(K_WRITE, 2'd0, 2'd0, 2'd1, 32'hFFFFFFFF, 0, lat, d1, d2);
      run_cmd(K_WRITE, 2'd0, 2'd0, 2'd2, 32'd1, 0, lat, d1, d2);
      run_cmd(K_ADD, 2'd1, 2'd2, 2'd1, 32'h0, 0, lat, d1, d2);
      chk("add_lat", lat, 3);
      check_writes("add", 1, 1, 0);
      chk("add_sum", d1, 32'h0);
      chk("add_carry", d2, 32'h1);
      run_cmd(K_READ, 2'd1, 2'd2, 2'd0, 32'h0, 0, lat, d1, d2);
      chk("add_rb_r1", d1, 32'h0);
      chk("add_rb_r2", d2, 32'h1);

      run_cmd(K_WRITE, 2'd0, 2'd0, 2'd0, 32'hA5A5A5A5, 0, lat, d1, d2);
      run_cmd(K_WRITE, 2'd0, 2'd0, 2'd3, 32'h0000FFFF, 0, lat, d1, d2);
      run_cmd(K_SWAP, 2'd0, 2'd3, 2'd0, 32'h0, 0, lat, d1, d2);
      chk("swap_lat", lat, 4);
      check_writes("swap", 2, 0, 3);
      chk("swap_d1", d1, 32'hA5A5A5A5);
      chk("swap_d2", d2, 32'h0000FFFF);
      run_cmd(K_READ, 2'd0, 2'd3, 2'd0, 32'h0, 5, lat, d1, d2);
      chk("swap_rb_r0", d1, 32'h0000FFFF);
      chk("swap_rb_r3", d2, 32'hA5A5A5A5);
      run_cmd(K_READ, 2'd0, 2'd0, 2'd0, 32'h0, 0, lat, d1, d2);
      chk("stall_cmd_ignored", d1, 32'h0000FFFF);

      run_cmd(K_SWAP, 2'd2, 2'd2, 2'd0, 32'h0, 0, lat, d1, d2);
      check_writes("swap_same", 2, 2, 2);
      chk("swap_same_d1", d1, 32'h1);
      chk("swap_same_d2", d2, 32'h1);
      run_cmd(K_READ, 2'd2, 2'd2, 2'd0, 32'h0, 0, lat, d1, d2);
      chk("swap_same_rb", d1, 32'h1);

      // Reset arriving while the first SWAP write is in progress.
      @(negedge clk);
      cmd_op = K_SWAP; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_wr1_we", rf_reg_write, 1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_we_drop", rf_reg_write, 0);
      chk("rstmid_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("rstmid_no_rsp", seen, 0);
      chk("rstmid_cmd_ready", cmd_ready, 1);
      run_cmd(K_READ, 2'd1, 2'd0, 2'd0, 32'h0, 0, lat, d1, d2);
      chk("rstmid_rb_r1", d1, 32'h1);
      chk("rstmid_rb_r0", d2, 32'h0000FFFF);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
